// File: rtl/sram_port_arbiter_if.sv
// Bundle of the fetch, data and SRAM-side signals of the SRAM port arbiter.
// master = requesters and SRAM model side, slave = arbiter side.
interface sram_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_addr_ok;
    logic        if_data_ok;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_addr_ok;
    logic        dm_data_ok;
    logic [31:0] dm_rdata;

    logic        sram_en;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, sram_rdata,
        input  if_addr_ok, if_data_ok, if_rdata, dm_addr_ok, dm_data_ok, dm_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, sram_rdata,
        output if_addr_ok, if_data_ok, if_rdata, dm_addr_ok, dm_data_ok, dm_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and data access,
// data first, with a starvation bound for fetch and a saturating conflict counter.
module sram_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic               clk,
    input  logic               reset,
    sram_port_arbiter_if.slave bus,
    output logic [CNT_W-1:0]   conflict_cnt
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IF,
        ST_DM
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       starve_q, starve_d;
    logic [CNT_W-1:0] conflict_q, conflict_d;
    logic             grant_if, grant_dm;
    logic             conflict;

    assign conflict     = bus.if_req & bus.dm_req;
    assign conflict_cnt = conflict_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            starve_q   <= '0;
            conflict_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            conflict_q <= conflict_d;
        end
    end

    // The last-winner state doubles as the response pipeline:
    // ST_IDLE = no response pending, ST_IF / ST_DM = response owner.
    always_comb begin
        state_d = ST_IDLE;
        if (grant_if) begin
            state_d = ST_IF;
        end else if (grant_dm) begin
            state_d = ST_DM;
        end

        starve_d = starve_q;
        if (grant_if || !bus.if_req) begin
            starve_d = '0;
        end else if (grant_dm && starve_q != LIMIT) begin
            starve_d = starve_q + 4'd1;
        end

        conflict_d = conflict_q;
        if (conflict && !(&conflict_q)) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
    end

    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (!reset) begin
            if (conflict) begin
                if (starve_q == LIMIT) begin
                    grant_if = 1'b1;
                end else begin
                    grant_dm = 1'b1;
                end
            end else begin
                grant_if = bus.if_req;
                grant_dm = bus.dm_req;
            end
        end

        bus.if_addr_ok = grant_if;
        bus.dm_addr_ok = grant_dm;
        bus.sram_en    = grant_if | grant_dm;
        bus.sram_we    = grant_dm & bus.dm_we;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        if (grant_dm) begin
            bus.sram_addr  = bus.dm_addr;
            bus.sram_wdata = bus.dm_wdata;
        end else if (grant_if) begin
            bus.sram_addr  = bus.if_addr;
        end

        bus.if_data_ok = (state_q == ST_IF);
        bus.dm_data_ok = (state_q == ST_DM);
        bus.if_rdata   = bus.if_data_ok ? bus.sram_rdata : '0;
        bus.dm_rdata   = bus.dm_data_ok ? bus.sram_rdata : '0;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small synchronous SRAM model.
module tb_sram_port_arbiter;
    logic        clk;
    logic        reset;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
    logic [31:0] rq;
    logic [31:0] wmem [logic [31:0]];
    int          total;
    int          bad;

    sram_port_arbiter_if b ();
    sram_port_arbiter_if b2 ();

    sram_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (b),
        .conflict_cnt (cnt)
    );

    sram_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .bus          (b2),
        .conflict_cnt (cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h1c00_0000: rom = 32'h0280_0401;
            32'h0000_0200: rom = 32'h1111_2222;
            32'h0000_0300: rom = 32'h3333_4444;
            default:       rom = 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (b.sram_en) begin
            if (b.sram_we) begin
                wmem[b.sram_addr] = b.sram_wdata;
                rq <= 32'h0;
            end else begin
                rq <= wmem.exists(b.sram_addr) ? wmem[b.sram_addr] : rom(b.sram_addr);
            end
        end
    end
    assign b.sram_rdata  = rq;
    assign b2.sram_rdata = 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rq    = 32'h0;
        reset = 1'b1;
        b.if_req = 1'b1; b.if_addr = 32'h0;
        b.dm_req = 1'b1; b.dm_we = 1'b0; b.dm_addr = 32'h0; b.dm_wdata = 32'h0;
        b2.if_req = 1'b0; b2.if_addr = 32'h0;
        b2.dm_req = 1'b0; b2.dm_we = 1'b0; b2.dm_addr = 32'h0; b2.dm_wdata = 32'h0;

        // reset state, requests ignored while reset is high
        cyc; cyc;
        chk("rst_if_addr_ok", b.if_addr_ok, 0);
        chk("rst_dm_addr_ok", b.dm_addr_ok, 0);
        chk("rst_sram_en", b.sram_en, 0);
        chk("rst_sram_addr", b.sram_addr, 0);
        chk("rst_data_ok", {b.if_data_ok, b.dm_data_ok}, 0);
        chk("rst_conflict", cnt, 0);
        b.if_req = 1'b0; b.dm_req = 1'b0;
        reset = 1'b0;
        cyc;

        // single fetch
        b.if_req = 1'b1; b.if_addr = 32'h1c00_0000;
        #1;
        chk("fetch_addr_ok", b.if_addr_ok, 1);
        chk("fetch_sram_en", b.sram_en, 1);
        chk("fetch_sram_we", b.sram_we, 0);
        chk("fetch_sram_addr", b.sram_addr, 64'h1c00_0000);
        cyc;
        b.if_req = 1'b0;
        #1;
        chk("fetch_data_ok", b.if_data_ok, 1);
        chk("fetch_rdata", b.if_rdata, 64'h0280_0401);
        chk("fetch_dm_data_ok", b.dm_data_ok, 0);
        chk("fetch_idle_sram_en", b.sram_en, 0);

        // write then read the same address, back to back
        b.dm_req = 1'b1; b.dm_we = 1'b1; b.dm_addr = 32'h100; b.dm_wdata = 32'hdead_beef;
        #1;
        chk("wr_addr_ok", b.dm_addr_ok, 1);
        chk("wr_sram_we", b.sram_we, 1);
        chk("wr_sram_wdata", b.sram_wdata, 64'hdead_beef);
        cyc;
        b.dm_we = 1'b0; b.dm_wdata = 32'h0;
        #1;
        chk("wr_done", b.dm_data_ok, 1);
        chk("rd_sram_we", b.sram_we, 0);
        chk("rd_sram_en", b.sram_en, 1);
        cyc;
        b.dm_req = 1'b0;
        #1;
        chk("rd_data_ok", b.dm_data_ok, 1);
        chk("rd_rdata", b.dm_rdata, 64'hdead_beef);
        chk("rd_if_data_ok", b.if_data_ok, 0);

        // one conflict cycle: data first, fetch next
        b.if_req = 1'b1; b.if_addr = 32'h300;
        b.dm_req = 1'b1; b.dm_we = 1'b0; b.dm_addr = 32'h200;
        #1;
        chk("cf_dm_addr_ok", b.dm_addr_ok, 1);
        chk("cf_if_addr_ok", b.if_addr_ok, 0);
        chk("cf_sram_addr", b.sram_addr, 64'h200);
        cyc;
        b.dm_req = 1'b0;
        #1;
        chk("cf_cnt", cnt, 1);
        chk("cf_dm_data_ok", b.dm_data_ok, 1);
        chk("cf_dm_rdata", b.dm_rdata, 64'h1111_2222);
        chk("cf_if_addr_ok2", b.if_addr_ok, 1);
        chk("cf_sram_addr2", b.sram_addr, 64'h300);
        cyc;
        b.if_req = 1'b0;
        #1;
        chk("cf_if_data_ok", b.if_data_ok, 1);
        chk("cf_if_rdata", b.if_rdata, 64'h3333_4444);
        chk("cf_dm_data_ok2", b.dm_data_ok, 0);

        // starvation: both held, fetch forced in on every fifth cycle
        b.if_req = 1'b1; b.dm_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("starve_if_%0d", i), b.if_addr_ok, (i % 5 == 4) ? 1 : 0);
            chk($sformatf("starve_dm_%0d", i), b.dm_addr_ok, (i % 5 == 4) ? 0 : 1);
            cyc;
        end
        #1;
        chk("starve_cnt", cnt, 9);

        // reset in the middle of a granted data read
        chk("mid_dm_addr_ok", b.dm_addr_ok, 1);
        chk("mid_dm_data_ok_pre", b.dm_data_ok, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_addr_ok", {b.if_addr_ok, b.dm_addr_ok}, 0);
        chk("mid_rst_sram_en", b.sram_en, 0);
        chk("mid_rst_data_ok", b.dm_data_ok, 0);
        chk("mid_rst_cnt", cnt, 0);
        b.if_req = 1'b0; b.dm_req = 1'b0;
        cyc;
        chk("mid_after_edge_data_ok", b.dm_data_ok, 0);
        chk("mid_after_edge_rdata", b.dm_rdata, 0);
        reset = 1'b0;
        cyc;
        chk("post_rst_data_ok", {b.if_data_ok, b.dm_data_ok}, 0);
        chk("post_rst_cnt", cnt, 0);
        b.if_req = 1'b1; b.dm_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("post_rst_if_%0d", i), b.if_addr_ok, (i == 4) ? 1 : 0);
            cyc;
        end
        b.if_req = 1'b0; b.dm_req = 1'b0;
        #1;
        chk("post_rst_cnt5", cnt, 5);

        // conflict counter saturation on the 4-bit instance
        b2.if_req = 1'b1; b2.dm_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc;
            if (i == 3)  chk("sat_cnt_3", cnt4, 3);
            if (i == 15) chk("sat_cnt_15", cnt4, 15);
        end
        chk("sat_cnt_20", cnt4, 15);
        b2.if_req = 1'b0; b2.dm_req = 1'b0;
        cyc;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
